// File: rtl/key_press_counter_leds.sv
// Debounced push-button press counter driving LEDG, with press strobe and long-press flag.
// Optional KEY_HOLD_AUTOREPEAT_EN: auto-repeat presses while the key is held.
module key_press_counter_leds #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000
) (
   input  logic       EXTCLK,
   input  logic       RST_N,
   input  logic       KEY_IN,
   output logic [7:0] LEDG,
   output logic       press_pulse,
   output logic       hold_flag
);

   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef KEY_HOLD_AUTOREPEAT_EN
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_DB,
      PRESSED,
      RELEASE_DB
   } state_t;

   state_t        state_q;
   logic          sync1_q;
   logic          sync_q;
   logic [DW-1:0] db_cnt_q;
   logic [HW-1:0] hold_cnt_q;
   logic [7:0]    count_q;
   logic          pulse_q;
   logic          hold_q;

   assign LEDG        = count_q;
   assign press_pulse = pulse_q;
   assign hold_flag   = hold_q;

   always_ff @(posedge EXTCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= RELEASED;
         sync1_q    <= 1'b1;
         sync_q     <= 1'b1;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         count_q    <= '0;
         pulse_q    <= 1'b0;
         hold_q     <= 1'b0;
      end else begin
         sync1_q <= KEY_IN;
         sync_q  <= sync1_q;
         pulse_q <= 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (!sync_q) begin
                  state_q  <= PRESS_DB;
                  db_cnt_q <= '0;
               end
            end
            PRESS_DB: begin
               if (sync_q) begin
                  state_q <= RELEASED;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q    <= PRESSED;
                  pulse_q    <= 1'b1;
                  count_q    <= count_q + 8'd1;
                  hold_cnt_q <= '0;
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (sync_q) begin
                  state_q  <= RELEASE_DB;
                  db_cnt_q <= '0;
               end else if (!hold_q) begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     hold_q <= 1'b1;
`ifdef KEY_HOLD_AUTOREPEAT_EN
                     // counter is reused as the repeat timer once held
                     hold_cnt_q <= '0;
`endif
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end else begin
`ifdef KEY_HOLD_AUTOREPEAT_EN
                  if (hold_cnt_q == REP_LAST) begin
                     pulse_q    <= 1'b1;
                     count_q    <= count_q + 8'd1;
                     hold_cnt_q <= '0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
`endif
               end
            end
            RELEASE_DB: begin
               if (!sync_q) begin
                  state_q <= PRESSED;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q    <= RELEASED;
                  hold_q     <= 1'b0;
                  hold_cnt_q <= '0;
               end else begin
                  db_cnt_q <= db_cnt_q + 1'b1;
               end
            end
            default: state_q <= RELEASED;
         endcase
      end
   end

endmodule

// File: tb/tb_key_press_counter_leds.sv
// Directed bench for key_press_counter_leds with DEBOUNCE=4, HOLD=16, REPEAT=8.
module tb_key_press_counter_leds;

   logic       EXTCLK;
   logic       RST_N;
   logic       KEY_IN;
   logic [7:0] LEDG;
   logic       press_pulse;
   logic       hold_flag;

   int checks;
   int failures;
   int pulse_cnt;
   int base_pulses;
   logic [7:0] exp_led;

`ifdef KEY_HOLD_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   key_press_counter_leds #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(16),
      .REPEAT_CYCLES(8)
   ) dut (
      .EXTCLK(EXTCLK),
      .RST_N(RST_N),
      .KEY_IN(KEY_IN),
      .LEDG(LEDG),
      .press_pulse(press_pulse),
      .hold_flag(hold_flag)
   );

   initial begin
      EXTCLK = 1'b0;
      forever #5 EXTCLK = ~EXTCLK;
   end

   always @(negedge EXTCLK) begin
      if (press_pulse === 1'b1) pulse_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic k, input int n);
      repeat (n) begin
         KEY_IN = k;
         @(posedge EXTCLK);
         #1;
      end
   endtask

   task automatic press_once();
      drive(1'b0, 8);
      drive(1'b1, 8);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      pulse_cnt = 0;
      exp_led   = 8'd0;
      RST_N     = 1'b0;
      KEY_IN    = 1'b1;
      repeat (3) @(posedge EXTCLK);
      #1;
      chk("reset_ledg", {24'b0, LEDG}, 32'd0);
      chk("reset_pulse", {31'b0, press_pulse}, 32'd0);
      chk("reset_hold", {31'b0, hold_flag}, 32'd0);
      RST_N = 1'b1;
      drive(1'b1, 4);

      // clean press: pulse only in the cycle after edge 6
      base_pulses = pulse_cnt;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1);
         if (i == 6) exp_led = exp_led + 8'd1;
         chk("clean_pulse", {31'b0, press_pulse}, {31'b0, (i == 6)});
         chk("clean_ledg", {24'b0, LEDG}, {24'b0, exp_led});
      end
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1);
         chk("clean_rel_pulse", {31'b0, press_pulse}, 32'd0);
         chk("clean_hold", {31'b0, hold_flag}, 32'd0);
      end
      chk("clean_pulses", pulse_cnt - base_pulses, 32'd1);
      chk("clean_ledg_end", {24'b0, LEDG}, 32'd1);

      // bounce rejection
      base_pulses = pulse_cnt;
      drive(1'b0, 2);
      drive(1'b1, 1);
      drive(1'b0, 2);
      drive(1'b1, 10);
      chk("bounce_pulses", pulse_cnt - base_pulses, 32'd0);
      chk("bounce_ledg", {24'b0, LEDG}, {24'b0, exp_led});

      // long hold: PRESSED at edge 6, hold at 22, release first sampled at 40
      base_pulses = pulse_cnt;
      for (int i = 0; i < 56; i++) begin
         logic ep;
         drive((i < 40) ? 1'b0 : 1'b1, 1);
         ep = (i == 6) || (AR && (i == 30 || i == 38));
         if (ep) exp_led = exp_led + 8'd1;
         chk("hold_pulse", {31'b0, press_pulse}, {31'b0, ep});
         chk("hold_flag", {31'b0, hold_flag}, {31'b0, (i >= 22 && i < 46)});
      end
      chk("hold_ledg", {24'b0, LEDG}, AR ? 32'd4 : 32'd2);
      chk("hold_pulses", pulse_cnt - base_pulses, AR ? 32'd3 : 32'd1);

      // release glitch: one high sample while PRESSED
      base_pulses = pulse_cnt;
      drive(1'b0, 10);
      exp_led = exp_led + 8'd1;
      chk("glitch_ledg_a", {24'b0, LEDG}, {24'b0, exp_led});
      drive(1'b1, 1);
      drive(1'b0, 10);
      chk("glitch_hold_lo", {31'b0, hold_flag}, 32'd0);
      chk("glitch_ledg_b", {24'b0, LEDG}, {24'b0, exp_led});
      drive(1'b0, 10);
      chk("glitch_hold_hi", {31'b0, hold_flag}, 32'd1);
      chk("glitch_pulses", pulse_cnt - base_pulses, 32'd1);
      drive(1'b1, 12);
      chk("glitch_hold_clr", {31'b0, hold_flag}, 32'd0);

      // wrap: 256 presses from a fresh reset
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      drive(1'b1, 2);
      chk("wrap_start", {24'b0, LEDG}, 32'd0);
      base_pulses = pulse_cnt;
      for (int i = 0; i < 255; i++) press_once();
      chk("wrap_255", {24'b0, LEDG}, 32'd255);
      press_once();
      chk("wrap_0", {24'b0, LEDG}, 32'd0);
      chk("wrap_pulses", pulse_cnt - base_pulses, 32'd256);

      // reset mid-press with LEDG = 5
      for (int i = 0; i < 4; i++) press_once();
      drive(1'b0, 8);
      chk("mid_ledg5", {24'b0, LEDG}, 32'd5);
      #2;
      RST_N = 1'b0;
      #1;
      chk("mid_rst_ledg", {24'b0, LEDG}, 32'd0);
      chk("mid_rst_pulse", {31'b0, press_pulse}, 32'd0);
      chk("mid_rst_hold", {31'b0, hold_flag}, 32'd0);
      @(posedge EXTCLK);
      #1;
      RST_N = 1'b1;
      base_pulses = pulse_cnt;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1);
         chk("mid_pulse", {31'b0, press_pulse}, {31'b0, (i == 6)});
      end
      chk("mid_ledg1", {24'b0, LEDG}, 32'd1);
      chk("mid_pulses", pulse_cnt - base_pulses, 32'd1);
      drive(1'b1, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
